// File: rtl/ps2_key_event.sv
// ps2_key_event
//   Scan-code sequencer that sits behind the PS/2 byte receiver. It takes one
//   validated byte per strobe and tracks the Set-2 prefixes: E0 marks an
//   extended key and F0 marks a break. Each complete key press or release
//   becomes one 10-bit event {ext, brk, code}. Events are queued in a
//   first-word-fall-through FIFO. Keyboard status bytes do not enter the FIFO;
//   they are reported on their own strobe instead.
//
// Parameters
//   DEPTH    event FIFO entries (power of two, >= 2)
//   TIMEOUT  maximum clk cycles allowed between a prefix byte and the next byte
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   byte_valid      one-cycle strobe: byte_data holds a newly received byte
//   byte_data[7:0]  received byte
//   evt_valid       FIFO head is valid
//   evt_data[9:0]   {ext, brk, code[7:0]} at the FIFO head (0 while empty)
//   evt_ready       consumer takes the head when evt_valid & evt_ready
//   evt_count       FIFO fill level, 0..DEPTH
//   status_valid    one-cycle pulse: a status byte was seen
//   status_code     last status byte seen
//   proto_err       one-cycle pulse on an illegal prefix sequence or timeout
//   overflow        sticky flag: an event was dropped because the FIFO was full
//   clr_ovf         synchronous clear of overflow (a new drop in the same
//                   cycle wins)
//
// Build option
//   PS2_KEY_EVENT_TIMEOUT_EN  when defined, the FSM returns to IDLE and pulses
//                             proto_err if no byte arrives within TIMEOUT
//                             cycles of a prefix byte. When undefined, the FSM
//                             waits in the prefix states indefinitely.
module ps2_key_event #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     evt_valid,
  output logic [9:0]               evt_data,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     status_valid,
  output logic [7:0]               status_code,
  output logic                     proto_err,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          status_valid_q, status_valid_d;
  logic [7:0]    status_code_q, status_code_d;
  logic          proto_err_q, proto_err_d;
  logic          overflow_q, overflow_d;
  logic [9:0]    mem_q [DEPTH];

  logic          push;
  logic [9:0]    push_data;
  logic          pop;
  logic          full;
  logic          accept;

`ifdef PS2_KEY_EVENT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
`endif

  // Status bytes are only recognised in IDLE; after a prefix they are codes.
  function automatic logic is_status(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
           (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  // Prefix sequencer: decides the next state, any event to push, and the pulses.
  always_comb begin
    state_d        = state_q;
    push           = 1'b0;
    push_data      = '0;
    status_valid_d = 1'b0;
    status_code_d  = status_code_q;
    proto_err_d    = 1'b0;
    if (byte_valid) begin
      case (state_q)
        IDLE: begin
          if (byte_data == 8'hE0) begin
            state_d = EXT;
          end else if (byte_data == 8'hF0) begin
            state_d = BRK;
          end else if (is_status(byte_data)) begin
            status_valid_d = 1'b1;
            status_code_d  = byte_data;
          end else begin
            push      = 1'b1;
            push_data = {2'b00, byte_data};
          end
        end
        EXT: begin
          // A repeated E0 is tolerated and leaves the FSM in EXT.
          if (byte_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (byte_data != 8'hE0) begin
            push      = 1'b1;
            push_data = {2'b10, byte_data};
            state_d   = IDLE;
          end
        end
        BRK: begin
          state_d = IDLE;
          if ((byte_data == 8'hE0) || (byte_data == 8'hF0)) begin
            proto_err_d = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {2'b01, byte_data};
          end
        end
        default: begin
          state_d = IDLE;
          if ((byte_data == 8'hE0) || (byte_data == 8'hF0)) begin
            proto_err_d = 1'b1;
          end else begin
            push      = 1'b1;
            push_data = {2'b11, byte_data};
          end
        end
      endcase
    end

`ifdef PS2_KEY_EVENT_TIMEOUT_EN
    // The timer counts idle cycles spent in a prefix state. A byte arriving in
    // the expiry cycle restarts it, so that byte is processed normally.
    tmr_d = '0;
    if (!byte_valid && (state_q != IDLE)) begin
      if (tmr_q == TW'(TIMEOUT - 1)) begin
        state_d     = IDLE;
        proto_err_d = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
`endif
  end

  // FIFO bookkeeping. When the FIFO is full, a push is still accepted if a pop
  // happens in the same cycle.
  always_comb begin
    pop      = evt_valid & evt_ready;
    full     = (count_q == (AW + 1)'(DEPTH));
    accept   = push & (~full | pop);
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (push && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      status_valid_q <= 1'b0;
      status_code_q  <= '0;
      proto_err_q    <= 1'b0;
      overflow_q     <= 1'b0;
`ifdef PS2_KEY_EVENT_TIMEOUT_EN
      tmr_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      status_valid_q <= status_valid_d;
      status_code_q  <= status_code_d;
      proto_err_q    <= proto_err_d;
      overflow_q     <= overflow_d;
`ifdef PS2_KEY_EVENT_TIMEOUT_EN
      tmr_q          <= tmr_d;
`endif
    end
  end

  // The storage array has no reset. Stale entries are never visible because
  // evt_data is forced to 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign evt_valid    = (count_q != '0);
  assign evt_data     = evt_valid ? mem_q[rd_ptr_q] : 10'h000;
  assign evt_count    = count_q;
  assign status_valid = status_valid_q;
  assign status_code  = status_code_q;
  assign proto_err    = proto_err_q;
  assign overflow     = overflow_q;

endmodule
